// File: rtl/program_loader.sv
// program_loader: byte-stream loader that assembles little-endian words and writes IM/DM, then hands off to the core on GO.
// Optional block checksum byte enabled by defining LOADER_CHECKSUM_EN.
module program_loader #(
    parameter int ADDRESS_WIDTH = 11,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    output logic                     in_ready,
    input  logic                     reload,
    output logic                     loading,
    output logic                     im_cen_load,
    output logic                     im_wen_load,
    output logic                     im_oen_load,
    output logic [ADDRESS_WIDTH-1:0] im_addr_load,
    output logic [DATA_WIDTH-1:0]    im_datain_load,
    output logic                     dm_cen_load,
    output logic                     dm_wen_load,
    output logic                     dm_oen_load,
    output logic [ADDRESS_WIDTH-1:0] dm_addr_load,
    output logic [DATA_WIDTH-1:0]    dm_datain_load,
    output logic                     err
);
    localparam logic [2:0] S_HDR   = 3'd0;
    localparam logic [2:0] S_DATA  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_CSUM  = 3'd4;

    logic [2:0]               r_state;
    logic [1:0]               r_bcnt;
    logic [23:0]              r_buf;
    logic                     r_dm;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [ADDRESS_WIDTH-1:0] r_left;
    logic [ADDRESS_WIDTH-1:0] r_im_addr;
    logic [ADDRESS_WIDTH-1:0] r_dm_addr;
    logic [DATA_WIDTH-1:0]    r_im_data;
    logic [DATA_WIDTH-1:0]    r_dm_data;
    logic                     r_err;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]               r_csum;
`endif

    logic                  w_fire;
    logic                  w_last;
    logic                  w_wr;
    logic [DATA_WIDTH-1:0] w_word;

    assign in_ready = (r_state == S_HDR) || (r_state == S_DATA) || (r_state == S_CSUM);
    assign w_fire   = in_valid && in_ready;
    assign w_last   = w_fire && (r_bcnt == 2'd3) && (r_state != S_CSUM);
    // bytes shift in from the top, so after three bytes r_buf holds {b2,b1,b0}
    assign w_word   = {in_data, r_buf};
    assign w_wr     = r_state == S_WRITE;

    assign loading        = r_state != S_RUN;
    assign im_cen_load    = !(w_wr && !r_dm);
    assign im_wen_load    = !(w_wr && !r_dm);
    assign im_oen_load    = 1'b1;
    assign dm_cen_load    = !(w_wr && r_dm);
    assign dm_wen_load    = !(w_wr && r_dm);
    assign dm_oen_load    = 1'b1;
    assign im_addr_load   = r_im_addr;
    assign im_datain_load = r_im_data;
    assign dm_addr_load   = r_dm_addr;
    assign dm_datain_load = r_dm_data;
    assign err            = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_HDR;
            r_bcnt    <= 2'd0;
            r_buf     <= '0;
            r_dm      <= 1'b0;
            r_addr    <= '0;
            r_left    <= '0;
            r_im_addr <= '0;
            r_dm_addr <= '0;
            r_im_data <= '0;
            r_dm_data <= '0;
            r_err     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_csum    <= 8'd0;
`endif
        end else begin
            if (w_fire && r_state != S_CSUM) begin
                r_bcnt <= r_bcnt + 2'd1;
                r_buf  <= {in_data, r_buf[23:8]};
            end
`ifdef LOADER_CHECKSUM_EN
            // the first header byte restarts the running block checksum
            if (w_fire)
                r_csum <= (r_state == S_HDR && r_bcnt == 2'd0) ? in_data : r_csum ^ in_data;
`endif
            case (r_state)
                S_HDR: if (w_last) begin
                    if (|(w_word & 32'h3800_F800))
                        r_err <= 1'b1;
                    if (w_word[30]) begin
                        r_state <= S_RUN;
                    end else begin
                        r_dm    <= w_word[31];
                        r_addr  <= w_word[ADDRESS_WIDTH-1:0];
                        r_left  <= w_word[16 +: ADDRESS_WIDTH];
                        r_state <= S_DATA;
                    end
                end
                S_DATA: if (w_last) begin
                    if (r_dm) begin
                        r_dm_addr <= r_addr;
                        r_dm_data <= w_word;
                    end else begin
                        r_im_addr <= r_addr;
                        r_im_data <= w_word;
                    end
                    r_state <= S_WRITE;
                end
                S_WRITE: begin
                    r_addr <= r_addr + 1'b1;
                    if (r_left == '0) begin
`ifdef LOADER_CHECKSUM_EN
                        r_state <= S_CSUM;
`else
                        r_state <= S_HDR;
`endif
                    end else begin
                        r_left  <= r_left - 1'b1;
                        r_state <= S_DATA;
                    end
                end
                S_RUN: if (reload) r_state <= S_HDR;
`ifdef LOADER_CHECKSUM_EN
                S_CSUM: if (w_fire) begin
                    if ((r_csum ^ in_data) != 8'd0)
                        r_err <= 1'b1;
                    r_state <= S_HDR;
                end
`endif
                default: r_state <= S_HDR;
            endcase
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: table-driven blocks with a write scoreboard, plus reset, GO/reload and error sequences.
module tb_program_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready;
    logic        reload = 1'b0;
    logic        loading;
    logic        im_cen_load, im_wen_load, im_oen_load;
    logic [10:0] im_addr_load;
    logic [31:0] im_datain_load;
    logic        dm_cen_load, dm_wen_load, dm_oen_load;
    logic [10:0] dm_addr_load;
    logic [31:0] dm_datain_load;
    logic        err;

    program_loader dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .reload(reload), .loading(loading),
        .im_cen_load(im_cen_load), .im_wen_load(im_wen_load), .im_oen_load(im_oen_load),
        .im_addr_load(im_addr_load), .im_datain_load(im_datain_load),
        .dm_cen_load(dm_cen_load), .dm_wen_load(dm_wen_load), .dm_oen_load(dm_oen_load),
        .dm_addr_load(dm_addr_load), .dm_datain_load(dm_datain_load), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        dm;
        logic [10:0] a;
        logic [31:0] d;
    } wr_t;

    typedef struct packed {
        logic [31:0]      hdr;
        logic [1:0][31:0] w;
        logic             exp_err;
    } vec_t;

    wr_t        q[$];
    vec_t       vecs[5];
    int         n_vec = 0;
    int         n_fail = 0;
    logic [7:0] csum;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // every write strobe must match the oldest expected write
    always @(negedge clk) begin
        if (!im_cen_load || !dm_cen_load) begin
            wr_t got;
            wr_t exp;
            got = {!dm_cen_load, dm_cen_load ? im_addr_load : dm_addr_load,
                   dm_cen_load ? im_datain_load : dm_datain_load};
            n_vec++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got %h expected none", got);
            end else begin
                exp = q.pop_front();
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL write: got %h expected %h", got, exp);
                end
                chk("strobes", {26'd0, im_cen_load, im_wen_load, im_oen_load, dm_cen_load, dm_wen_load, dm_oen_load},
                    {26'd0, exp.dm ? 6'b111001 : 6'b001111});
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t == 50) chk("ready_timeout", {31'd0, in_ready}, 32'd1);
        csum = csum ^ b;
        in_valid = 1'b1;
        in_data = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic send_block(input logic [31:0] hdr, input logic [1:0][31:0] w, input logic bad_csum);
        logic [10:0] a;
        logic [7:0]  c;
        int          n;
        a = hdr[10:0];
        n = int'(hdr[26:16]) + 1;
        csum = 8'd0;
        send_word(hdr);
        for (int i = 0; i < n; i++) begin
            q.push_back({hdr[31], a, w[i]});
            send_word(w[i]);
            a = a + 11'd1;
        end
        c = csum ^ (bad_csum ? 8'h5A : 8'h00);
`ifdef LOADER_CHECKSUM_EN
        send_byte(c);
`endif
    endtask

    task automatic drain(input string name);
        for (int t = 0; t < 20 && q.size() != 0; t++) @(negedge clk);
        chk(name, q.size(), 0);
    endtask

    initial begin
        vecs[0] = '{hdr: 32'h0001_0010, w: {32'hDEADBEEF, 32'h12345678}, exp_err: 1'b0};
        vecs[1] = '{hdr: 32'h8000_07FF, w: {32'h0, 32'h00000001}, exp_err: 1'b0};
        vecs[2] = '{hdr: 32'h8001_07FF, w: {32'h0BADF00D, 32'hAAAA5555}, exp_err: 1'b0};
        vecs[3] = '{hdr: 32'h0000_1003, w: {32'h0, 32'hCAFEBABE}, exp_err: 1'b1};
        vecs[4] = '{hdr: 32'h8000_0100, w: {32'h0, 32'h11223344}, exp_err: 1'b1};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_loading", {31'd0, loading}, 32'd1);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_ctl", {26'd0, im_cen_load, im_wen_load, im_oen_load, dm_cen_load, dm_wen_load, dm_oen_load}, 32'h3F);
        chk("rst_im_addr", {21'd0, im_addr_load}, 32'd0);
        chk("rst_dm_data", dm_datain_load, 32'd0);

        // abandon a word two bytes into DATA
        send_word(32'h0000_0005);
        send_byte(8'h11);
        send_byte(8'h22);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_loading", {31'd0, loading}, 32'd1);
        chk("midrst_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_im_addr", {21'd0, im_addr_load}, 32'd0);

        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        chk("reload_in_hdr", {31'd0, loading}, 32'd1);

        for (int i = 0; i < 5; i++) begin
            send_block(vecs[i].hdr, vecs[i].w, 1'b0);
            drain("block_drain");
            chk("block_err", {31'd0, err}, {31'd0, vecs[i].exp_err});
        end
        chk("im_addr_hold", {21'd0, im_addr_load}, 32'd3);
        chk("im_data_hold", im_datain_load, 32'hCAFEBABE);
        chk("dm_addr_hold", {21'd0, dm_addr_load}, 32'h100);

        csum = 8'd0;
        send_word(32'h4000_0000);
        chk("go_loading", {31'd0, loading}, 32'd0);
        chk("go_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b1;
        in_data = 8'hAA;
        repeat (6) @(negedge clk);
        in_valid = 1'b0;
        chk("run_loading", {31'd0, loading}, 32'd0);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        chk("reload_loading", {31'd0, loading}, 32'd1);
        chk("reload_ready", {31'd0, in_ready}, 32'd1);
        chk("err_sticky", {31'd0, err}, 32'd1);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("err_cleared", {31'd0, err}, 32'd0);

        csum = 8'd0;
        send_word(32'h4800_0000);
        chk("go_bad_loading", {31'd0, loading}, 32'd0);
        chk("go_bad_err", {31'd0, err}, 32'd1);

`ifdef LOADER_CHECKSUM_EN
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        send_block(32'h0000_0040, {32'h0, 32'h01020304}, 1'b0);
        drain("csum_ok_drain");
        chk("csum_ok_err", {31'd0, err}, 32'd0);
        send_block(32'h8000_0041, {32'h0, 32'hA5A5A5A5}, 1'b1);
        drain("csum_bad_drain");
        @(negedge clk);
        chk("csum_bad_err", {31'd0, err}, 32'd1);
`endif

        repeat (3) @(negedge clk);
        chk("final_queue", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
